// File: rtl/updown_counter_pkg.sv
// Shared constants and the control-priority decode for the up/down counter.
package updown_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_MODULUS = 256;

    // Operation selected on a clock edge after priority resolution.
    typedef enum logic [1:0] {
        OpHold,
        OpClear,
        OpLoad,
        OpCount
    } op_e;

    // clear beats load, load beats en; nothing asserted means hold.
    function automatic op_e decode_op(logic clear, logic load, logic en);
        if (clear) begin
            return OpClear;
        end
        if (load) begin
            return OpLoad;
        end
        if (en) begin
            return OpCount;
        end
        return OpHold;
    endfunction

endpackage

// File: rtl/updown_counter_if.sv
// Control and status bundle of the up/down counter.
interface updown_counter_if
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             wrap;

    // Controlling side: drives the controls, observes the count.
    modport master (
        output clear, load, load_val, en, up,
        input  count, at_max, at_min, wrap
    );

    // Counter side.
    modport slave (
        input  clear, load, load_val, en, up,
        output count, at_max, at_min, wrap
    );

endinterface

// File: rtl/updown_counter_next.sv
// Combinational next-state logic: next count value and wrap pulse.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned MODULUS  = DEFAULT_MODULUS,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    op_e op;

    // Resolve control priority, then step/clamp the count within 0..MAX_VAL.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        op         = decode_op(clear, load, en);
        unique case (op)
            OpClear: begin
                count_next = '0;
            end
            OpLoad: begin
                count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            end
            OpCount: begin
                if (up) begin
                    if (count != MAX_VAL) begin
                        count_next = count + WIDTH'(1);
                    end else if (SATURATE == 0) begin
                        count_next = '0;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    if (count != '0) begin
                        count_next = count - WIDTH'(1);
                    end else if (SATURATE == 0) begin
                        count_next = MAX_VAL;
                        wrap_next  = 1'b1;
                    end
                end
            end
            default: begin
                count_next = count;
            end
        endcase
    end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter: register stage plus boundary decode.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned MODULUS  = DEFAULT_MODULUS,
    parameter int unsigned SATURATE = 0
) (
    input  logic           clk,
    input  logic           reset,
    updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

    updown_counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .clear      (bus.clear),
        .load       (bus.load),
        .load_val   (bus.load_val),
        .en         (bus.en),
        .up         (bus.up),
        .count_next (count_d),
        .wrap_next  (wrap_d)
    );

    // Count and wrap registers; reset forces zero without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Flags decode straight from the register so they align with count.
    always_comb begin
        bus.count  = count_q;
        bus.wrap   = wrap_q;
        bus.at_max = (count_q == MAX_VAL);
        bus.at_min = (count_q == '0);
    end

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench: three counter configurations driven in lockstep,
// expected values queued at drive time and compared after each edge.
module tb_updown_counter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    updown_counter_if #(.WIDTH(8)) if0 ();
    updown_counter_if #(.WIDTH(4)) if1 ();
    updown_counter_if #(.WIDTH(4)) if2 ();

    updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    typedef struct {
        int d;
        int cnt;
        bit wrap;
    } exp_t;

    exp_t sb[$];
    int   mods[3] = '{256, 10, 10};
    bit   sats[3] = '{1'b0, 1'b0, 1'b1};
    int   m_cnt[3];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_next(input int c, input bit clr, input bit ld, input int lv,
                                      input bit en, input bit up, input int mod, input bit sat,
                                      output bit w);
        w = 1'b0;
        if (clr) return 0;
        if (ld) return (lv > mod - 1) ? mod - 1 : lv;
        if (!en) return c;
        if (up) begin
            if (c < mod - 1) return c + 1;
            if (sat) return c;
            w = 1'b1;
            return 0;
        end
        if (c > 0) return c - 1;
        if (sat) return c;
        w = 1'b1;
        return mod - 1;
    endfunction

    function automatic int dut_count(input int d);
        case (d)
            0:       return int'(if0.count);
            1:       return int'(if1.count);
            default: return int'(if2.count);
        endcase
    endfunction

    // {wrap, at_max, at_min}
    function automatic logic [2:0] dut_flags(input int d);
        case (d)
            0:       return {if0.wrap, if0.at_max, if0.at_min};
            1:       return {if1.wrap, if1.at_max, if1.at_min};
            default: return {if2.wrap, if2.at_max, if2.at_min};
        endcase
    endfunction

    task automatic drive(input bit clr, input bit ld, input logic [7:0] lv, input bit en,
                         input bit up);
        exp_t e;
        bit   w;
        int   lvd;
        if0.clear = clr; if0.load = ld; if0.load_val = lv;      if0.en = en; if0.up = up;
        if1.clear = clr; if1.load = ld; if1.load_val = lv[3:0]; if1.en = en; if1.up = up;
        if2.clear = clr; if2.load = ld; if2.load_val = lv[3:0]; if2.en = en; if2.up = up;
        for (int d = 0; d < 3; d++) begin
            lvd = (d == 0) ? int'(lv) : int'(lv[3:0]);
            if (reset) begin
                m_cnt[d] = 0;
                w = 1'b0;
            end else begin
                m_cnt[d] = model_next(m_cnt[d], clr, ld, lvd, en, up, mods[d], sats[d], w);
            end
            e.d = d;
            e.cnt = m_cnt[d];
            e.wrap = w;
            sb.push_back(e);
        end
    endtask

    task automatic compare();
        exp_t       e;
        logic [2:0] f;
        for (int k = 0; k < 3; k++) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                f = dut_flags(e.d);
                check($sformatf("count%0d", e.d), dut_count(e.d), e.cnt);
                check($sformatf("wrap%0d", e.d), int'(f[2]), int'(e.wrap));
                check($sformatf("at_max%0d", e.d), int'(f[1]), int'(e.cnt == mods[e.d] - 1));
                check($sformatf("at_min%0d", e.d), int'(f[0]), int'(e.cnt == 0));
            end
        end
    endtask

    task automatic cycle(input bit clr, input bit ld, input logic [7:0] lv, input bit en,
                         input bit up);
        @(negedge clk);
        drive(clr, ld, lv, en, up);
        @(posedge clk);
        #1;
        compare();
    endtask

    // Assert reset between edges and check it acts without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) m_cnt[d] = 0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async_rst_count%0d", d), dut_count(d), 0);
            check($sformatf("async_rst_flags%0d", d), int'(dut_flags(d)), 3'b001);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        void'(sb.pop_front());
        void'(sb.pop_front());
        void'(sb.pop_front());
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] lv;
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        check("reset_count", int'(if0.count), 0);
        check("reset_flags", int'({if0.wrap, if0.at_max, if0.at_min}), 3'b001);
        release_reset();

        // Reset mid-count, then held for three enabled edges.
        cycle(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        check("load_5a", int'(if0.count), 8'h5A);
        async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("rst_hold", int'(if0.count), 0);
        release_reset();

        // Full-range wrap from 0xFE upward.
        cycle(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("ff_count", int'(if0.count), 8'hFF);
        check("ff_at_max", int'(if0.at_max), 1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("wrap_count", int'(if0.count), 0);
        check("wrap_pulse", int'(if0.wrap), 1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("wrap_end", int'(if0.wrap), 0);

        // Downward boundary: wrap vs saturate.
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("m10_down_count", int'(if1.count), 9);
        check("m10_down_wrap", int'(if1.wrap), 1);
        check("sat_down_count", int'(if2.count), 0);
        check("sat_down_wrap", int'(if2.wrap), 0);

        // Load clamp, then clear overriding load.
        cycle(1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
        check("clamp1", int'(if1.count), 9);
        check("clamp2", int'(if2.count), 9);
        cycle(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);
        check("clear_wins", int'(if1.count), 0);

        // Disabled with direction toggling, then load overriding en.
        cycle(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, i[0]);
        check("en0_hold", int'(if0.count), 7);
        cycle(1'b0, 1'b1, 8'h03, 1'b1, 1'b1);
        check("load_over_en", int'(if0.count), 3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                async_reset();
                cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'($urandom));
                release_reset();
            end
            case ($urandom_range(0, 3))
                0:       lv = 8'h00;
                1:       lv = 8'hFF;
                default: lv = 8'($urandom);
            endcase
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, lv,
                  $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
